// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver.
// Glyphs are active-low, bit 6 = segment a ... bit 0 = segment g.
package seg7_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'h01;
  localparam logic [6:0] GLYPH_1 = 7'h4F;
  localparam logic [6:0] GLYPH_2 = 7'h12;
  localparam logic [6:0] GLYPH_3 = 7'h06;
  localparam logic [6:0] GLYPH_4 = 7'h4C;
  localparam logic [6:0] GLYPH_5 = 7'h24;
  localparam logic [6:0] GLYPH_6 = 7'h20;
  localparam logic [6:0] GLYPH_7 = 7'h0F;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h04;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h60;
  localparam logic [6:0] GLYPH_C = 7'h31;
  localparam logic [6:0] GLYPH_D = 7'h42;
  localparam logic [6:0] GLYPH_E = 7'h30;
  localparam logic [6:0] GLYPH_F = 7'h38;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-glyph decoder (active-low segments).
// Ports:
//   nibble_i  4-bit value to display
//   seg_o     active-low segments, seg_o[6]=a ... seg_o[0]=g
// Macro SEG7_HEX_DIGITS_EN: when defined, 10..15 decode to A b C d E F;
// otherwise they decode to blank.
module seg7_glyph
  import seg7_pkg::*;
(
  input  nibble_t    nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0:    seg_o = GLYPH_0;
      4'h1:    seg_o = GLYPH_1;
      4'h2:    seg_o = GLYPH_2;
      4'h3:    seg_o = GLYPH_3;
      4'h4:    seg_o = GLYPH_4;
      4'h5:    seg_o = GLYPH_5;
      4'h6:    seg_o = GLYPH_6;
      4'h7:    seg_o = GLYPH_7;
      4'h8:    seg_o = GLYPH_8;
      4'h9:    seg_o = GLYPH_9;
`ifdef SEG7_HEX_DIGITS_EN
      4'hA:    seg_o = GLYPH_A;
      4'hB:    seg_o = GLYPH_B;
      4'hC:    seg_o = GLYPH_C;
      4'hD:    seg_o = GLYPH_D;
      4'hE:    seg_o = GLYPH_E;
      4'hF:    seg_o = GLYPH_F;
`endif
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with a double-buffered
// value, leading-zero blanking, decimal points, one dead-time cycle per
// digit slot and a frame strobe.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       capture value_i/dp_i into the shadow buffer
//   value_i      nibble per digit, nibble 0 = rightmost digit
//   dp_i         decimal-point request per digit (1 = lit)
//   blank_lz_i   enable leading-zero blanking
//   enable_i     0 forces all anodes off
//   seg_o, dp_o  active-low segments / decimal point
//   an_o         active-low anode enables
//   frame_o      one-cycle pulse after the scan wraps to digit 0
// Macro SEG7_HEX_DIGITS_EN enables hex glyphs in the decoder.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    blank_lz_i,
  input  logic                    enable_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d, active_val_q, active_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q, frame_d;

  logic                    slot_end, frame_end;
  nibble_t                 cur_nib;
  logic                    cur_dp, cur_lz, zero_run;
  logic [6:0]              glyph;

  // Counters and buffer transfer.
  always_comb begin
    slot_end  = (div_q == DIV_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    div_d     = slot_end ? '0 : div_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    pending_d    = pending_q;
    if (load_i) begin
      shadow_val_d = value_i;
      shadow_dp_d  = dp_i;
    end
    // Transfers happen only at the frame boundary so a frame never mixes
    // two loads; a load on the boundary itself bypasses the shadow.
    if (frame_end) begin
      if (load_i) begin
        active_val_d = value_i;
        active_dp_d  = dp_i;
        pending_d    = 1'b0;
      end else if (pending_q) begin
        active_val_d = shadow_val_q;
        active_dp_d  = shadow_dp_q;
        pending_d    = 1'b0;
      end
    end else if (load_i) begin
      pending_d = 1'b1;
    end
  end

  // Select the current digit; zero_run accumulates "this nibble and all
  // nibbles above it are zero" while walking down from the top digit.
  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_lz   = 1'b0;
    zero_run = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_run = zero_run & (active_val_q[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        cur_nib = active_val_q[4*i +: 4];
        cur_dp  = active_dp_q[i];
        cur_lz  = zero_run;
      end
    end
  end

  seg7_glyph u_glyph (
    .nibble_i (cur_nib),
    .seg_o    (glyph)
  );

  always_comb begin
    seg_d   = (blank_lz_i && (idx_q != '0) && cur_lz) ? SEG_BLANK : glyph;
    dp_d    = ~cur_dp;
    // Slot cycle 0 is dead time: all anodes off to avoid ghosting.
    an_d    = (enable_i && (div_q != '0)) ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    frame_d = frame_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_q      <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_q      <= frame_d;
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 4 cycles per slot).
// The reference model works in terms of elapsed cycles since reset release:
// slot position = cyc % 4, digit = (cyc / 4) % 4, frame boundary at
// cyc % 16 == 15.
module tb_seg7_scan_driver;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_i;
  logic [15:0]   value_i;
  logic [3:0]    dp_i;
  logic          blank_lz_i;
  logic          enable_i;
  logic [6:0]    seg_o;
  logic          dp_o;
  logic [3:0]    an_o;
  logic          frame_o;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int            cyc;
  logic [15:0]   m_shadow, m_active;
  logic [3:0]    m_sdp, m_adp;
  bit            m_pend;
  logic [6:0]    glyph_tab [16];

  seg7_scan_driver #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_i),
    .value_i    (value_i),
    .dp_i       (dp_i),
    .blank_lz_i (blank_lz_i),
    .enable_i   (enable_i),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .an_o       (an_o),
    .frame_o    (frame_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got %h exp %h", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_an", 7'(an_o), 7'h0F);
    chk("rst_seg", seg_o, 7'h7F);
    chk("rst_dp", 7'(dp_o), 7'h01);
    chk("rst_frame", 7'(frame_o), 7'h00);
  endtask

  task automatic model_reset();
    cyc      = 0;
    m_shadow = '0;
    m_active = '0;
    m_sdp    = '0;
    m_adp    = '0;
    m_pend   = 1'b0;
  endtask

  // Predict the outputs produced by the coming edge, advance the model,
  // then sample after the edge.
  task automatic step();
    int         slot_pos, dig;
    logic [3:0] nib;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp, exp_fr;
    bit         boundary;
    slot_pos = cyc % DIV;
    dig      = (cyc / DIV) % N;
    boundary = (cyc % (DIV * N)) == (DIV * N - 1);
    exp_an   = 4'hF;
    if (enable_i && slot_pos != 0) exp_an[dig] = 1'b0;
    nib = m_active[4*dig +: 4];
    if (blank_lz_i && dig != 0 && (m_active >> (4 * dig)) == 16'h0) exp_seg = 7'h7F;
    else exp_seg = glyph_tab[nib];
    exp_dp = ~m_adp[dig];
    exp_fr = boundary;
    if (load_i) begin
      m_shadow = value_i;
      m_sdp    = dp_i;
      if (boundary) begin
        m_active = value_i;
        m_adp    = dp_i;
        m_pend   = 1'b0;
      end else begin
        m_pend = 1'b1;
      end
    end else if (boundary && m_pend) begin
      m_active = m_shadow;
      m_adp    = m_sdp;
      m_pend   = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
    chk("an_o", 7'(an_o), 7'(exp_an));
    chk("seg_o", seg_o, exp_seg);
    chk("dp_o", 7'(dp_o), 7'(exp_dp));
    chk("frame_o", 7'(frame_o), 7'(exp_fr));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    load_i  = 1'b1;
    value_i = v;
    dp_i    = d;
    step();
    load_i  = 1'b0;
  endtask

  initial begin
    glyph_tab = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
`ifdef SEG7_HEX_DIGITS_EN
                  7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
`else
                  7'h00, 7'h04, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif
    rst_n      = 1'b1;
    load_i     = 1'b0;
    value_i    = '0;
    dp_i       = '0;
    blank_lz_i = 1'b0;
    enable_i   = 1'b1;
    model_reset();

    // Power-on reset, checked asynchronously before any clock edge.
    #2 rst_n = 1'b0;
    #1 chk_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Free-running scan, no load.
    run(37);

    // Reset asserted mid-slot takes effect without a clock edge.
    #3 rst_n = 1'b0;
    #1 chk_reset();
    @(posedge clk);
    #1 chk_reset();
    rst_n = 1'b1;
    model_reset();
    run(6);

    // Mid-frame load: unchanged until the next boundary.
    load(16'h1234, 4'b0010);
    run(40);

    // Two loads in one frame: last wins, 1-glyph never shown.
    run(3);
    load(16'h1111, 4'b0000);
    run(2);
    load(16'h2222, 4'b0000);
    run(36);

    // Leading-zero blanking.
    blank_lz_i = 1'b1;
    load(16'h0070, 4'b0000);
    run(36);
    load(16'h0000, 4'b0001);
    run(36);
    blank_lz_i = 1'b0;
    run(20);

    // Hex nibbles.
    load(16'h00AF, 4'b0000);
    run(36);
    blank_lz_i = 1'b1;
    run(20);

    // Load coincident with the frame boundary goes straight to active.
    while (cyc % (DIV * N) != DIV * N - 1) step();
    load(16'h9876, 4'b1000);
    run(20);

    // Enable off: anodes stay high, counters continue.
    enable_i = 1'b0;
    run(20);
    enable_i = 1'b1;
    run(10);

    // Randomised traffic against the model.
    for (int k = 0; k < 800; k++) begin
      load_i  = ($urandom_range(0, 7) == 0);
      value_i = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value_i = value_i & 16'h00FF;
      dp_i    = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz_i = ~blank_lz_i;
      if ($urandom_range(0, 31) == 0) enable_i = ~enable_i;
      step();
    end
    load_i = 1'b0;
    run(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
